// File: rtl/dcache_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_unit
//  Purpose  : Direct-mapped, write-back, write-allocate data cache between a
//             byte-wide CPU load/store port and a word-block data memory.
//             8 lines x 4 bytes; address = {tag[7:5], index[4:2], offset[1:0]}.
//             Hits complete with no stall. A miss stalls the CPU, writes back
//             a dirty victim if needed, then refills the line from memory.
//  Ports    : CLK, RESET (sync, active-low)
//             CPU side : read, write, address[7:0], writedata[7:0],
//                        readdata[7:0], busywait
//             Mem side : mem_read, mem_write, mem_address[5:0],
//                        mem_writedata[31:0], mem_readdata[31:0], mem_busywait
//             Optional : hit_count[15:0], miss_count[15:0]
//  Config   : `define DCACHE_PERF_CNT_EN to add the hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        read,
   input  logic        write,
   input  logic [7:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   output logic        busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_valid;
   logic [7:0]  r_dirty;
   logic [2:0]  r_tag  [0:7];
   logic [31:0] r_data [0:7];

   logic        r_mem_read;
   logic        r_mem_write;
   logic [5:0]  r_mem_address;
   logic [31:0] r_mem_writedata;
   // Tag of the block being fetched, captured at the miss so the fill does
   // not depend on the CPU still presenting the address.
   logic [2:0]  r_fill_tag;

   logic [2:0]  w_tag;
   logic [2:0]  w_index;
   logic [1:0]  w_offset;
   logic        w_req;
   logic        w_hit;
   logic [31:0] w_line;
   logic        w_idle_hit;
   logic        w_wr_hit;
   logic        w_fill;

   assign w_tag      = address[7:5];
   assign w_index    = address[4:2];
   assign w_offset   = address[1:0];
   assign w_req      = read | write;
   assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_line     = r_data[w_index];
   assign w_idle_hit = (r_state == ST_IDLE) && w_hit;
   // A simultaneous read+write is a write.
   assign w_wr_hit   = RESET && write && w_idle_hit;
   assign w_fill     = RESET && (r_state == ST_FETCH) && !mem_busywait;

   assign busywait      = RESET && w_req && !w_idle_hit;
   assign mem_read      = r_mem_read;
   assign mem_write     = r_mem_write;
   assign mem_address   = r_mem_address;
   assign mem_writedata = r_mem_writedata;

   always_comb begin
      readdata = 8'h00;
      if (read && !write) begin
         readdata = w_line[{w_offset, 3'b000} +: 8];
      end
   end

   // Tag/data arrays carry no reset; valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (w_wr_hit) begin
         r_data[w_index][{w_offset, 3'b000} +: 8] <= writedata;
      end
      if (w_fill) begin
         r_data[r_mem_address[2:0]] <= mem_readdata;
         r_tag[r_mem_address[2:0]]  <= r_fill_tag;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state         <= ST_IDLE;
         r_valid         <= 8'h00;
         r_dirty         <= 8'h00;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_address   <= 6'h00;
         r_mem_writedata <= 32'h0;
         r_fill_tag      <= 3'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_hit) begin
                     if (write) begin
                        r_dirty[w_index] <= 1'b1;
                     end
                  end else begin
                     r_fill_tag <= w_tag;
                     if (r_valid[w_index] && r_dirty[w_index]) begin
                        r_mem_write     <= 1'b1;
                        r_mem_address   <= {r_tag[w_index], w_index};
                        r_mem_writedata <= w_line;
                        r_state         <= ST_WRITEBACK;
                     end else begin
                        r_mem_read    <= 1'b1;
                        r_mem_address <= {w_tag, w_index};
                        r_state       <= ST_FETCH;
                     end
                  end
               end
            end
            ST_WRITEBACK: begin
               if (!mem_busywait) begin
                  // Switch straight from write-back to fetch; never both high.
                  r_mem_write   <= 1'b0;
                  r_mem_read    <= 1'b1;
                  r_mem_address <= {r_fill_tag, r_mem_address[2:0]};
                  r_state       <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (!mem_busywait) begin
                  r_mem_read                 <= 1'b0;
                  r_valid[r_mem_address[2:0]] <= 1'b1;
                  r_dirty[r_mem_address[2:0]] <= 1'b0;
                  r_state                    <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   // The cycle after a fill is the retried access of the miss; its hit is
   // part of that miss and is not counted as a hit.
   logic        r_retry;
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_retry      <= 1'b0;
         r_hit_count  <= 16'h0000;
         r_miss_count <= 16'h0000;
      end else begin
         r_retry <= w_fill;
         if (w_req && w_idle_hit && !r_retry && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
         end
         if (w_req && (r_state == ST_IDLE) && !w_hit && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_unit
//  Purpose  : Directed self-checking bench for dcache_unit with a word memory
//             model that holds mem_busywait high for MEM_LAT cycles per access.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_unit;

   localparam int MEM_LAT = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
`ifdef DCACHE_PERF_CNT_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int checks   = 0;
   int failures = 0;

   dcache_unit dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Memory model
   logic [31:0] mem_word [0:63];
   int          lat_cnt = 0;
   int          wr_cycles = 0;
   int          both_cycles = 0;

   assign mem_busywait = (mem_read | mem_write) && (lat_cnt != MEM_LAT);
   assign mem_readdata = mem_word[mem_address];

   always @(posedge CLK) begin
      if (!(mem_read | mem_write) || lat_cnt == MEM_LAT) lat_cnt <= 0;
      else lat_cnt <= lat_cnt + 1;
      if (mem_write && !mem_busywait) mem_word[mem_address] <= mem_writedata;
      if (mem_write) wr_cycles <= wr_cycles + 1;
      if (mem_write && mem_read) both_cycles <= both_cycles + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance until busywait drops (bounded); returns the number of edges taken.
   task automatic wait_ready(input string tag, output int cyc);
      cyc = 0;
      while (busywait && cyc < 40) begin
         tick();
         cyc++;
      end
      if (busywait) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout observed=busy expected=ready", tag);
      end
   endtask

   int cyc;
   int wr_snap;

   initial begin
      for (int i = 0; i < 64; i++) mem_word[i] = 32'h0;
      mem_word[6'h01] = 32'hDDCCBBAA;
      mem_word[6'h09] = 32'h44332211;
      mem_word[6'h11] = 32'h88776655;
      RESET = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
      tick(); tick();
      RESET = 1'b1;
      #1;
      check("rst_busywait", {31'b0, busywait}, 32'd0);
      check("rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check("rst_readdata", {24'b0, readdata}, 32'h00);

      // Scenario 1: clean cold miss on 8'h05
      read = 1'b1; address = 8'h05;
      #1;
      check("s1_busy_now", {31'b0, busywait}, 32'd1);
      tick();
      check("s1_fetch_rd", {31'b0, mem_read}, 32'd1);
      check("s1_fetch_wr", {31'b0, mem_write}, 32'd0);
      check("s1_fetch_addr", {26'b0, mem_address}, 32'h01);
      wait_ready("s1", cyc);
      check("s1_fetch_len", cyc, MEM_LAT + 1);
      check("s1_readdata", {24'b0, readdata}, 32'hBB);
      check("s1_mem_read_off", {31'b0, mem_read}, 32'd0);
      tick();
      read = 1'b0;

      // Scenario 2: write hit then read hit
      write = 1'b1; address = 8'h05; writedata = 8'h5A;
      #1;
      check("s2_wr_nostall", {31'b0, busywait}, 32'd0);
      tick();
      write = 1'b0; read = 1'b1;
      #1;
      check("s2_rd_nostall", {31'b0, busywait}, 32'd0);
      check("s2_readdata", {24'b0, readdata}, 32'h5A);
      check("s2_no_mem", {30'b0, mem_read, mem_write}, 32'd0);
      tick();
      read = 1'b0;

      // Scenario 3: dirty conflict miss, read 8'h25
      read = 1'b1; address = 8'h25;
      #1;
      check("s3_busy_now", {31'b0, busywait}, 32'd1);
      tick();
      check("s3_wb_wr", {31'b0, mem_write}, 32'd1);
      check("s3_wb_rd", {31'b0, mem_read}, 32'd0);
      check("s3_wb_addr", {26'b0, mem_address}, 32'h01);
      check("s3_wb_data", mem_writedata, 32'hDDCC5AAA);
      for (int i = 0; i < MEM_LAT + 1; i++) tick();
      check("s3_fetch_rd", {31'b0, mem_read}, 32'd1);
      check("s3_fetch_wr", {31'b0, mem_write}, 32'd0);
      check("s3_fetch_addr", {26'b0, mem_address}, 32'h09);
      wait_ready("s3", cyc);
      check("s3_fetch_len", cyc, MEM_LAT + 1);
      check("s3_readdata", {24'b0, readdata}, 32'h22);
      check("s3_mem_updated", mem_word[6'h01], 32'hDDCC5AAA);
      tick();
      read = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
      check("cnt_hit", {16'b0, hit_count}, 32'd2);
      check("cnt_miss", {16'b0, miss_count}, 32'd2);
`endif

      // Scenario 4: clean fill of 8'h05, then clean conflict 8'h45
      wr_snap = wr_cycles;
      read = 1'b1; address = 8'h05;
      #1;
      wait_ready("s4a", cyc);
      check("s4a_len", cyc, MEM_LAT + 2);
      check("s4a_readdata", {24'b0, readdata}, 32'h5A);
      tick();
      address = 8'h45;
      #1;
      check("s4_busy_now", {31'b0, busywait}, 32'd1);
      tick();
      check("s4_fetch_rd", {31'b0, mem_read}, 32'd1);
      check("s4_fetch_addr", {26'b0, mem_address}, 32'h11);
      wait_ready("s4b", cyc);
      check("s4_readdata", {24'b0, readdata}, 32'h66);
      check("s4_no_writeback", wr_cycles, wr_snap);
      tick();
      read = 1'b0;

      // Scenario 5: reset during FETCH
      read = 1'b1; address = 8'h05;
      #1;
      tick();
      check("s5_fetch_rd", {31'b0, mem_read}, 32'd1);
      RESET = 1'b0;
      tick();
      check("s5_rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("s5_rst_busy", {31'b0, busywait}, 32'd0);
      RESET = 1'b1;
      #1;
      check("s5_miss_again", {31'b0, busywait}, 32'd1);
      tick();
      check("s5_refetch_addr", {26'b0, mem_address}, 32'h01);
      wait_ready("s5", cyc);
      check("s5_readdata", {24'b0, readdata}, 32'h5A);
      tick();
      read = 1'b0;

      check("never_rd_and_wr", both_cycles, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
